// File: rtl/apb_slave_sched.sv
// apb_slave_sched: APB fan-out scheduler between the AXI-APB bridge and up to
// four peripherals; one transfer in flight, access timeout, sticky error status.
module apb_slave_sched #(
  parameter int NSLV = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int TMO = 256,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_psel,
  input  logic                   m_penable,
  input  logic                   m_pwrite,
  input  logic [ADDR_W-1:0]      m_paddr,
  input  logic [DATA_W-1:0]      m_pwdata,
  output logic [DATA_W-1:0]      m_prdata,
  output logic                   m_pready,
  output logic [NSLV-1:0]        s_psel,
  output logic                   s_penable,
  output logic                   s_pwrite,
  output logic [ADDR_W-1:0]      s_paddr,
  output logic [DATA_W-1:0]      s_pwdata,
  input  logic [NSLV*DATA_W-1:0] s_prdata,
  input  logic [NSLV-1:0]        s_pready,
  input  logic                   err_clr,
  output logic                   err_pulse,
  output logic [7:0]             err_cnt,
  output logic [ADDR_W-1:0]      err_addr,
  output logic                   err_type
);

  localparam logic [2:0] NSLV_L = 3'(NSLV);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;
  state_t state_d;

  logic              blank;
  logic [1:0]        idx_q;
  logic [15:0]       tmo_cnt;
  logic [1:0]        idx_in;
  logic              idx_ok;
  logic [NSLV-1:0]   sel_oh;
  logic              sel_rdy;
  logic [DATA_W-1:0] sel_rd;
  logic              go_start;
  logic              go_dec;
  logic              acc_done;
  logic              acc_tmo;
  logic              err_ev;
  logic              unused;

  // The upstream enable carries no information the scheduler needs.
  assign unused = m_penable;

  assign idx_in = m_paddr[ADDR_W-1 -: 2];
  assign idx_ok = {1'b0, idx_in} < NSLV_L;
  assign err_ev = go_dec | acc_tmo;

  // One-hot decode of the incoming index and mux of the selected slave.
  always_comb begin
    sel_oh  = '0;
    sel_rdy = 1'b0;
    sel_rd  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_in == 2'(i)) begin
        sel_oh[i] = 1'b1;
      end
      if (idx_q == 2'(i)) begin
        sel_rdy = s_pready[i];
        sel_rd  = s_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and transfer events; ready beats timeout.
  always_comb begin
    state_d  = state;
    go_start = 1'b0;
    go_dec   = 1'b0;
    acc_done = 1'b0;
    acc_tmo  = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_psel && !blank) begin
          go_start = 1'b1;
          if (idx_ok) begin
            state_d = SETUP;
          end else begin
            go_dec  = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_rdy) begin
          acc_done = 1'b1;
          state_d  = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          acc_tmo = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; blank masks the IDLE cycle right after a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      blank <= 1'b0;
    end else begin
      state <= state_d;
      blank <= (state == RESP);
    end
  end

  // Request latch: held stable from SETUP until the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_paddr  <= '0;
      s_pwdata <= '0;
      s_pwrite <= 1'b0;
      idx_q    <= '0;
    end else if (go_start) begin
      s_paddr  <= m_paddr;
      s_pwdata <= m_pwdata;
      s_pwrite <= m_pwrite;
      idx_q    <= idx_in;
    end
  end

  // Slave-side select and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_psel    <= '0;
      s_penable <= 1'b0;
    end else begin
      if (go_start && idx_ok) begin
        s_psel <= sel_oh;
      end else if (acc_done || acc_tmo) begin
        s_psel <= '0;
      end
      s_penable <= (state_d == ACCESS);
    end
  end

  // Access timer: cleared in SETUP, counts every ACCESS cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Response to the bridge: read data held until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_prdata <= '0;
      m_pready <= 1'b0;
    end else begin
      m_pready <= go_dec | acc_done | acc_tmo;
      if (acc_done) begin
        m_prdata <= s_pwrite ? '0 : sel_rd;
      end else if (err_ev) begin
        m_prdata <= ERR_DATA;
      end
    end
  end

  // Error status: address and type are sticky, count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_addr  <= '0;
      err_type  <= 1'b0;
    end else begin
      err_pulse <= err_ev;
      if (err_ev) begin
        err_addr <= go_dec ? m_paddr : s_paddr;
        err_type <= acc_tmo;
      end
    end
  end

  // Error counter; a clear coinciding with an error counts that error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= {7'd0, err_ev};
    end else if (err_ev && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_slave_sched.sv
// tb_apb_slave_sched: transaction-level timeline model for a 4-slave instance,
// plus directed decode-error checks on a 3-slave instance.
module tb_apb_slave_sched;

  localparam int NC  = 2048;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_psel = 1'b0;
  logic        m_penable;
  logic        m_pwrite = 1'b0;
  logic [19:0] m_paddr = '0;
  logic [31:0] m_pwdata = '0;
  logic        err_clr = 1'b0;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic [3:0]  s_psel;
  logic        s_penable;
  logic        s_pwrite;
  logic [19:0] s_paddr;
  logic [31:0] s_pwdata;
  logic [127:0] s_prdata;
  logic [3:0]  s_pready;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic [19:0] err_addr;
  logic        err_type;

  logic        b_psel = 1'b0;
  logic [19:0] b_paddr = '0;
  logic        b_clr = 1'b0;
  logic [31:0] b_prdata;
  logic        b_pready;
  logic [2:0]  b_spsel;
  logic        b_spen;
  logic        b_spwrite;
  logic [19:0] b_spaddr;
  logic [31:0] b_spwdata;
  logic [95:0] b_sprdata;
  logic [2:0]  b_spready;
  logic        b_epulse;
  logic [7:0]  b_ecnt;
  logic [19:0] b_eaddr;
  logic        b_etype;

  bit [31:0] sd [4] = '{32'hA0A0_0000, 32'hB1B1_1111,
                        32'h1234_5678, 32'h3333_CCCC};
  int wait_cfg [4] = '{0, 0, 0, 0};
  int acc_cnt = 0;
  int cyc = 0;

  assign m_penable = m_psel;
  assign s_prdata  = {sd[3], sd[2], sd[1], sd[0]};
  assign b_sprdata = {sd[2], sd[1], sd[0]};
  assign b_spready = 3'b111;

  apb_slave_sched #(.NSLV(4), .TMO(TMO)) u_a (
    .clk(clk), .rst(rst),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_prdata(m_prdata), .m_pready(m_pready),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_prdata(s_prdata), .s_pready(s_pready),
    .err_clr(err_clr), .err_pulse(err_pulse), .err_cnt(err_cnt),
    .err_addr(err_addr), .err_type(err_type)
  );

  apb_slave_sched #(.NSLV(3), .TMO(TMO)) u_b (
    .clk(clk), .rst(rst),
    .m_psel(b_psel), .m_penable(b_psel), .m_pwrite(m_pwrite),
    .m_paddr(b_paddr), .m_pwdata(m_pwdata),
    .m_prdata(b_prdata), .m_pready(b_pready),
    .s_psel(b_spsel), .s_penable(b_spen), .s_pwrite(b_spwrite),
    .s_paddr(b_spaddr), .s_pwdata(b_spwdata),
    .s_prdata(b_sprdata), .s_pready(b_spready),
    .err_clr(b_clr), .err_pulse(b_epulse), .err_cnt(b_ecnt),
    .err_addr(b_eaddr), .err_type(b_etype)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: ready after wait_cfg[i] wait states in ACCESS.
  always @(posedge clk) acc_cnt <= (rst || !s_penable) ? 0 : acc_cnt + 1;

  always_comb begin
    s_pready = '0;
    for (int i = 0; i < 4; i++) begin
      s_pready[i] = s_psel[i] && s_penable && (acc_cnt == wait_cfg[i]);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Expected timeline, indexed by cycle window.
  bit [3:0]  ex_psel [NC];
  bit        ex_pen  [NC];
  bit        ex_rdy  [NC];
  bit        ev_prd  [NC];
  bit [31:0] prd_val [NC];
  bit        ev_err  [NC];
  bit        ee_type [NC];
  bit [19:0] ee_addr [NC];
  bit        ev_lat  [NC];
  bit [19:0] la_addr [NC];
  bit        la_wr   [NC];
  bit [31:0] la_wd   [NC];
  bit        clr_at  [NC];
  bit        rst_at  [NC];
  int        next_ok = 0;
  bit        check_on = 1'b1;

  bit [31:0] md_prd = '0;
  int        md_cnt = 0;
  bit [19:0] md_eaddr = '0;
  bit        md_etype = 1'b0;
  bit [19:0] md_laddr = '0;
  bit        md_lwr = 1'b0;
  bit [31:0] md_lwd = '0;

  task automatic launch(input logic [19:0] a, input logic wr,
                        input logic [31:0] wd, output int t, output int r);
    int idx;
    int nacc;
    bit tmo;
    m_psel   = 1'b1;
    m_paddr  = a;
    m_pwrite = wr;
    m_pwdata = wd;
    t    = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
    idx  = int'(a[19:18]);
    tmo  = wait_cfg[idx] >= TMO;
    nacc = tmo ? TMO : wait_cfg[idx] + 1;
    ev_lat[t]  = 1'b1;
    la_addr[t] = a;
    la_wr[t]   = wr;
    la_wd[t]   = wd;
    for (int c = t; c <= t + nacc; c++) ex_psel[c] = 4'(1 << idx);
    for (int c = t + 1; c <= t + nacc; c++) ex_pen[c] = 1'b1;
    r = t + nacc + 1;
    ex_rdy[r] = 1'b1;
    ev_prd[r] = 1'b1;
    prd_val[r] = tmo ? 32'hDEAD_BEEF : (wr ? 32'h0 : sd[idx]);
    if (tmo) begin
      ev_err[r]  = 1'b1;
      ee_type[r] = 1'b1;
      ee_addr[r] = a;
    end
    next_ok = r + 3;
  endtask

  task automatic xfer(input logic [19:0] a, input logic wr,
                      input logic [31:0] wd, input bit scr, output int r);
    int t;
    launch(a, wr, wd, t, r);
    while (cyc < r) begin
      @(negedge clk);
      if (scr && cyc == t) begin
        m_paddr  = a ^ 20'h0_F0F0;
        m_pwdata = ~wd;
        m_pwrite = ~wr;
      end
    end
    m_psel = 1'b0;
  endtask

  task automatic cancel(input int from);
    for (int c = from; c < NC; c++) begin
      ex_psel[c] = '0;
      ex_pen[c]  = 1'b0;
      ex_rdy[c]  = 1'b0;
      ev_prd[c]  = 1'b0;
      ev_err[c]  = 1'b0;
      ev_lat[c]  = 1'b0;
    end
  endtask

  // Compare the 4-slave instance against the timeline every cycle.
  always @(negedge clk) begin : cmp
    int c;
    if (check_on && cyc < NC) begin
      c = cyc;
      if (rst_at[c]) begin
        md_prd = '0; md_cnt = 0; md_eaddr = '0; md_etype = 1'b0;
        md_laddr = '0; md_lwr = 1'b0; md_lwd = '0;
      end
      if (ev_lat[c]) begin
        md_laddr = la_addr[c]; md_lwr = la_wr[c]; md_lwd = la_wd[c];
      end
      if (ev_prd[c]) md_prd = prd_val[c];
      if (ev_err[c]) begin
        md_cnt   = clr_at[c] ? 1 : (md_cnt == 255 ? 255 : md_cnt + 1);
        md_eaddr = ee_addr[c];
        md_etype = ee_type[c];
      end else if (clr_at[c]) begin
        md_cnt = 0;
      end
      chk("s_psel", s_psel, ex_psel[c]);
      chk("s_penable", s_penable, ex_pen[c]);
      chk("m_pready", m_pready, ex_rdy[c]);
      chk("err_pulse", err_pulse, ev_err[c]);
      chk("m_prdata", m_prdata, md_prd);
      chk("err_cnt", err_cnt, md_cnt);
      chk("err_addr", err_addr, md_eaddr);
      chk("err_type", err_type, md_etype);
      chk("s_paddr", s_paddr, md_laddr);
      chk("s_pwrite", s_pwrite, md_lwr);
      chk("s_pwdata", s_pwdata, md_lwd);
    end
  end

  initial begin : stim
    int r;
    int r1;
    int t;
    int c0;
    int k;
    rst_at[1] = 1'b1;
    @(negedge clk);
    chk("rst_prdata", m_prdata, 0);
    chk("rst_pready", m_pready, 0);
    chk("rst_psel", s_psel, 0);
    chk("rst_ecnt", err_cnt, 0);
    chk("rst_b_psel", b_spsel, 0);
    chk("rst_b_ecnt", b_ecnt, 0);
    rst = 1'b0;
    @(negedge clk);

    c0 = cyc;
    xfer(20'h80010, 1'b0, 32'h0, 1'b0, r);
    chk("t1_lat", cyc - c0, 3);
    chk("t1_rdy", m_pready, 1);
    chk("t1_prd", m_prdata, 32'h1234_5678);
    chk("t1_epulse", err_pulse, 0);

    wait_cfg[1] = 5;
    repeat (2) @(negedge clk);
    c0 = cyc;
    xfer(20'h40004, 1'b1, 32'hA5A5_0001, 1'b1, r);
    chk("t2_lat", cyc - c0, 8);
    chk("t2_pwrite", s_pwrite, 1);
    chk("t2_pwdata", s_pwdata, 32'hA5A5_0001);
    chk("t2_paddr", s_paddr, 20'h40004);
    chk("t2_prd", m_prdata, 0);

    wait_cfg[0] = 1000;
    repeat (2) @(negedge clk);
    c0 = cyc;
    xfer(20'h00020, 1'b0, 32'h0, 1'b0, r);
    chk("t3_lat", cyc - c0, 18);
    chk("t3_prd", m_prdata, 32'hDEAD_BEEF);
    chk("t3_ecnt", err_cnt, 1);
    chk("t3_etype", err_type, 1);
    chk("t3_eaddr", err_addr, 20'h00020);

    wait_cfg[3] = 15;
    repeat (2) @(negedge clk);
    c0 = cyc;
    xfer(20'hC0008, 1'b0, 32'h0, 1'b0, r);
    chk("t4_lat", cyc - c0, 18);
    chk("t4_prd", m_prdata, 32'h3333_CCCC);
    chk("t4_ecnt", err_cnt, 1);

    wait_cfg[0] = 2;
    repeat (2) @(negedge clk);
    xfer(20'h80000, 1'b0, 32'h0, 1'b0, r1);
    xfer(20'h00004, 1'b1, 32'h0BAD_F00D, 1'b0, r);
    chk("t5_gap", r - r1, 7);
    chk("t5_cyc", cyc - r1, 7);

    @(negedge clk);
    err_clr = 1'b1;
    clr_at[cyc+1] = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t6_ecnt", err_cnt, 0);
    chk("t6_eaddr", err_addr, 20'h00020);

    wait_cfg[3] = 1000;
    repeat (2) @(negedge clk);
    launch(20'hC0010, 1'b0, 32'h0, t, r);
    while (cyc < t + 3) @(negedge clk);
    chk("t7_busy", s_penable, 1);
    rst = 1'b1;
    m_psel = 1'b0;
    cancel(cyc + 1);
    rst_at[cyc+1] = 1'b1;
    next_ok = cyc + 2;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_psel", s_psel, 0);
    chk("t7_pen", s_penable, 0);
    chk("t7_rdy", m_pready, 0);
    chk("t7_paddr", s_paddr, 0);
    wait_cfg[0] = 0;
    c0 = cyc;
    xfer(20'h0000C, 1'b0, 32'h0, 1'b0, r);
    chk("t7_lat", cyc - c0, 3);
    chk("t7_prd", m_prdata, 32'hA0A0_0000);

    m_pwrite = 1'b0;
    m_pwdata = 32'h55AA_1234;
    b_psel = 1'b1;
    b_paddr = 20'hC0000;
    @(negedge clk);
    chk("b1_rdy", b_pready, 1);
    chk("b1_prd", b_prdata, 32'hDEAD_BEEF);
    chk("b1_etype", b_etype, 0);
    chk("b1_eaddr", b_eaddr, 20'hC0000);
    chk("b1_ecnt", b_ecnt, 1);
    chk("b1_epulse", b_epulse, 1);
    chk("b1_spaddr", b_spaddr, 20'hC0000);
    chk("b1_spwrite", b_spwrite, 0);
    chk("b1_spwdata", b_spwdata, 32'h55AA_1234);
    for (int n = 2; n <= 256; n++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        chk("b_nosel", {b_spen, b_spsel}, 0);
      end while (!b_pready && k < 6);
      chk("b_gap", k, 3);
      chk("b_cnt", b_ecnt, (n > 255) ? 255 : n);
    end
    repeat (2) @(negedge clk);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    b_psel = 1'b0;
    chk("b_clr_rdy", b_pready, 1);
    chk("b_clr_err", b_ecnt, 1);
    repeat (2) @(negedge clk);
    b_clr = 1'b1;
    @(negedge clk);
    b_clr = 1'b0;
    chk("b_clr_only", b_ecnt, 0);
    chk("b_eaddr_kept", b_eaddr, 20'hC0000);
    chk("b_etype_kept", b_etype, 0);

    repeat (2) @(negedge clk);
    check_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
